// File: rtl/fifo_write_handler.sv
// fifo_write_handler: write-side pointer and status controller for a
// dual-clock FIFO whose depth need not be a power of two.
// The pointer is a wrap bit plus a binary index that counts 0..DEPTH-1.
// Full, fill level and almost-full are derived from the read pointer
// after it has been synchronized into the write domain.
// Optional feature macro: OVF_COUNT_EN adds a saturating 8-bit count of
// rejected writes on output ovf_count.
module fifo_write_handler #(
  parameter int ADDRSIZE     = 8,
  parameter int DEPTH        = 90,
  parameter int AFULL_THRESH = 80
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic                ovf_clr,
  input  logic [ADDRSIZE-1:0] rptr,
  output logic [ADDRSIZE-1:0] wptr,
  output logic [ADDRSIZE-2:0] waddr,
  output logic                wr_mem_en,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE-1:0] wlevel,
  output logic                wr_ack,
`ifdef OVF_COUNT_EN
  output logic                overflow,
  output logic [7:0]          ovf_count
`else
  output logic                overflow
`endif
);

  localparam logic [ADDRSIZE-2:0] LAST_IDX    = (ADDRSIZE-1)'(DEPTH - 1);
  localparam logic [ADDRSIZE-1:0] DEPTH_W     = ADDRSIZE'(DEPTH);
  localparam logic [ADDRSIZE-1:0] AFULL_W     = ADDRSIZE'(AFULL_THRESH);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic                wrAck_q, wrAck_d;
  logic                overflow_q, overflow_d;
  logic                wWrap, rWrap;
  logic [ADDRSIZE-2:0] wIdx, rIdx;
  logic [ADDRSIZE-1:0] wIdxExt, rIdxExt;
  logic                rejectedWrite;

  assign wWrap   = wptr_q[ADDRSIZE-1];
  assign rWrap   = rptr[ADDRSIZE-1];
  assign wIdx    = wptr_q[ADDRSIZE-2:0];
  assign rIdx    = rptr[ADDRSIZE-2:0];
  assign wIdxExt = {1'b0, wIdx};
  assign rIdxExt = {1'b0, rIdx};

  // Status from the current pointer pair; a stale rptr can only make the
  // FIFO look fuller than it is, so full is never optimistic.
  always_comb begin
    wfull = (wWrap != rWrap) && (wIdx == rIdx);
    if (wWrap == rWrap) begin
      wlevel = wIdxExt - rIdxExt;
    end else begin
      wlevel = DEPTH_W - rIdxExt + wIdxExt;
    end
    walmost_full = (wlevel >= AFULL_W);
  end

  assign wr_mem_en     = wr_en & ~wfull & ~wr_rst;
  assign rejectedWrite = wr_en & wfull;
  assign wptr          = wptr_q;
  assign waddr         = wIdx;
  assign wr_ack        = wrAck_q;
  assign overflow      = overflow_q;

  // Next pointer: the index wraps at DEPTH-1 (not at a power of two) and
  // toggles the wrap bit; the sticky overflow flag lets set beat clear.
  always_comb begin
    wptr_d = wptr_q;
    if (wr_mem_en) begin
      if (wIdx == LAST_IDX) begin
        wptr_d = {~wWrap, {(ADDRSIZE-1){1'b0}}};
      end else begin
        wptr_d = {wWrap, wIdx + 1'b1};
      end
    end
    wrAck_d    = wr_mem_en;
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (rejectedWrite) begin
      overflow_d = 1'b1;
    end
  end

  // Write-domain state registers with synchronous reset taking priority.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wptr_q     <= '0;
      wrAck_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      wrAck_q    <= wrAck_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef OVF_COUNT_EN
  logic [7:0] ovfCount_q, ovfCount_d;

  // Rejected-write counter: saturates at 255, and a clear that coincides
  // with a rejected write still records that one rejection.
  always_comb begin
    ovfCount_d = ovfCount_q;
    if (ovf_clr) begin
      ovfCount_d = rejectedWrite ? 8'd1 : 8'd0;
    end else if (rejectedWrite && (ovfCount_q != 8'hFF)) begin
      ovfCount_d = ovfCount_q + 8'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      ovfCount_q <= 8'd0;
    end else begin
      ovfCount_q <= ovfCount_d;
    end
  end

  assign ovf_count = ovfCount_q;
`endif

endmodule

// File: tb/tb_fifo_write_handler.sv
// tb_fifo_write_handler: directed, table-driven bench for fifo_write_handler
// with default parameters (ADDRSIZE=8, DEPTH=90, AFULL_THRESH=80).
// Honours OVF_COUNT_EN when it is defined for the build.
module tb_fifo_write_handler;

  logic       wr_clk;
  logic       wr_rst;
  logic       wr_en;
  logic       ovf_clr;
  logic [7:0] rptr;
  logic [7:0] wptr;
  logic [6:0] waddr;
  logic       wr_mem_en;
  logic       wfull;
  logic       walmost_full;
  logic [7:0] wlevel;
  logic       wr_ack;
  logic       overflow;
`ifdef OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int numChecks;
  int numFails;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] rptrIn;
    logic [7:0] expWptr;
    logic       expMemEn;
    logic       expFull;
    logic [7:0] expLevel;
    logic       expAfull;
    logic       expAck;
    logic       expOvf;
  } vec_t;

  vec_t vecs [8];

  fifo_write_handler #(
    .ADDRSIZE(8),
    .DEPTH(90),
    .AFULL_THRESH(80)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .wr_en(wr_en),
    .ovf_clr(ovf_clr),
    .rptr(rptr),
    .wptr(wptr),
    .waddr(waddr),
    .wr_mem_en(wr_mem_en),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wlevel(wlevel),
    .wr_ack(wr_ack),
`ifdef OVF_COUNT_EN
    .overflow(overflow),
    .ovf_count(ovf_count)
`else
    .overflow(overflow)
`endif
  );

  // Free-running write clock, period 10.
  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive inputs just after a rising edge and let combinational logic settle.
  task automatic applyStimulus(input logic rst, input logic en, input logic clr,
                               input logic [7:0] rp);
    wr_rst  = rst;
    wr_en   = en;
    ovf_clr = clr;
    rptr    = rp;
    #2;
  endtask

  // Advance one rising edge, then step clear of it.
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // Main sequence: table vectors first, then the multi-cycle corner cases.
  initial begin
    numChecks = 0;
    numFails  = 0;

    //            rst   en    clr   rptr   wptr   memEn full  level  afull ack   ovf
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    // Bring state out of X with one reset edge before the table.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].rptrIn);
      checkOutput($sformatf("vec%0d wptr", i), 32'(wptr), 32'(vecs[i].expWptr));
      checkOutput($sformatf("vec%0d wr_mem_en", i), 32'(wr_mem_en), 32'(vecs[i].expMemEn));
      checkOutput($sformatf("vec%0d wfull", i), 32'(wfull), 32'(vecs[i].expFull));
      checkOutput($sformatf("vec%0d wlevel", i), 32'(wlevel), 32'(vecs[i].expLevel));
      checkOutput($sformatf("vec%0d walmost_full", i), 32'(walmost_full), 32'(vecs[i].expAfull));
      checkOutput($sformatf("vec%0d wr_ack", i), 32'(wr_ack), 32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
      tick();
    end

    // Fill from empty with rptr=0: 90 back-to-back writes.
    for (int k = 0; k < 90; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("fill%0d waddr", k), 32'(waddr), 32'(k));
      checkOutput($sformatf("fill%0d wlevel", k), 32'(wlevel), 32'(k));
      checkOutput($sformatf("fill%0d walmost_full", k), 32'(walmost_full), (k >= 80) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill%0d wr_mem_en", k), 32'(wr_mem_en), 32'd1);
      checkOutput($sformatf("fill%0d wr_ack", k), 32'(wr_ack), (k > 0) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("full wptr", 32'(wptr), 32'h80);
    checkOutput("full wlevel", 32'(wlevel), 32'd90);
    checkOutput("full wfull", 32'(wfull), 32'd1);
    checkOutput("full walmost_full", 32'(walmost_full), 32'd1);
    checkOutput("full wr_ack", 32'(wr_ack), 32'd1);

    // Three writes against a full FIFO are all rejected.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("rej%0d wr_mem_en", k), 32'(wr_mem_en), 32'd0);
      checkOutput($sformatf("rej%0d wptr", k), 32'(wptr), 32'h80);
      checkOutput($sformatf("rej%0d wr_ack", k), 32'(wr_ack), (k == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rej%0d overflow", k), 32'(overflow), (k == 0) ? 32'd0 : 32'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rej wptr", 32'(wptr), 32'h80);
    checkOutput("rej wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("rej overflow", 32'(overflow), 32'd1);
`ifdef OVF_COUNT_EN
    checkOutput("rej ovf_count", 32'(ovf_count), 32'd3);
`endif

    // Clear coinciding with a rejected write: set wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("setwins overflow", 32'(overflow), 32'd1);
`ifdef OVF_COUNT_EN
    checkOutput("setwins ovf_count", 32'(ovf_count), 32'd1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("clr overflow", 32'(overflow), 32'd0);
`ifdef OVF_COUNT_EN
    checkOutput("clr ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Reader at wrap 0 index 80 while writer is at wrap 1 index 0: level 10.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h50);
      checkOutput($sformatf("wrap%0d wlevel", k), 32'(wlevel), 32'(10 + k));
      checkOutput($sformatf("wrap%0d wr_mem_en", k), 32'(wr_mem_en), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h50);
    checkOutput("wrap wptr", 32'(wptr), 32'h85);
    checkOutput("wrap waddr", 32'(waddr), 32'd5);
    checkOutput("wrap wlevel", 32'(wlevel), 32'd15);
    checkOutput("wrap wfull", 32'(wfull), 32'd0);
    checkOutput("wrap walmost_full", 32'(walmost_full), 32'd0);

    // Reset, then 10 writes, then reset with wr_en held high.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("midrst wptr before", 32'(wptr), 32'h0A);
    checkOutput("midrst wr_mem_en", 32'(wr_mem_en), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("midrst wptr after", 32'(wptr), 32'h00);
    checkOutput("midrst wr_ack", 32'(wr_ack), 32'd0);
    checkOutput("resume wr_mem_en", 32'(wr_mem_en), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("resume wptr", 32'(wptr), 32'h01);
    checkOutput("resume wr_ack", 32'(wr_ack), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/fifo_write_handler.md
Name: fifo_write_handler

Overview:
Write-side pointer and status controller for the dual-clock FIFO with non-power-of-two depth. It sits upstream of the FIFO memory and the read-side handler. It owns the write pointer (wrap bit plus binary index), generates the memory write strobe and address, and derives full, almost-full, fill level and overflow status from the read pointer already synchronized into the write domain.

Parameters:
ADDRSIZE, 8, pointer width: MSB is the wrap bit, [ADDRSIZE-2:0] is the index; DEPTH must be <= 2^(ADDRSIZE-1)
DEPTH, 90, number of FIFO memory locations
AFULL_THRESH, 80, fill level at or above which walmost_full asserts; must be 1..DEPTH

Ports:
wr_clk  input  1  write-domain clock
wr_rst  input  1  synchronous active-high reset
wr_en  input  1  write request from producer
ovf_clr  input  1  clears sticky overflow flag
rptr  input  ADDRSIZE  read pointer synchronized into wr_clk domain, same wrap+index format
wptr  output  ADDRSIZE  write pointer, registered, sent to read domain
waddr  output  ADDRSIZE-1  memory write address, equals wptr[ADDRSIZE-2:0]
wr_mem_en  output  1  memory write strobe, combinational: wr_en & !wfull & !wr_rst
wfull  output  1  FIFO full, combinational from wptr/rptr
walmost_full  output  1  wlevel >= AFULL_THRESH, combinational
wlevel  output  ADDRSIZE  fill level 0..DEPTH, combinational
wr_ack  output  1  registered; high one cycle after an accepted write
overflow  output  1  sticky; set by a write attempt while full

Behaviour:
- Reset (sampled on wr_clk rising edge, highest priority): wptr=0, wr_ack=0, overflow=0. With rptr=0, the combinational outputs settle to wfull=0, wlevel=0, walmost_full=0 (when AFULL_THRESH>=1), waddr=0.
- Accepted write: wr_en=1 and wfull=0. Memory write occurs on the same edge using waddr.
- Pointer advance on an accepted write:
  - index < DEPTH-1: index+1, wrap bit unchanged.
  - index == DEPTH-1: index=0, wrap bit toggles.
  - Otherwise wptr holds.
- Full: wrap bits differ and indices equal.
- Level:
  - Wrap bits equal: w_idx - r_idx.
  - Wrap bits differ: DEPTH - r_idx + w_idx.
  - Computed at ADDRSIZE width with no overflow, since DEPTH <= 2^(ADDRSIZE-1).
- wr_ack: next cycle equals the previous cycle's wr_mem_en. Reset forces 0.
- overflow:
  - Set on an edge where wr_en=1 and wfull=1.
  - Cleared on an edge where ovf_clr=1.
  - Set and clear in the same cycle: set wins.
  - Rejected writes leave wptr and memory untouched.
- Simultaneous read (rptr moves) and write in the same cycle: wptr advances per its own rule. wfull/wlevel reflect the rptr value present at that time; stale rptr only makes full pessimistic, never optimistic.
- Reset mid-burst: wr_en ignored during reset, wr_mem_en=0, no pointer advance.
- Latency: status outputs change combinationally in the same cycle as a wptr/rptr change; wptr updates one edge after acceptance.

Optional Feature:
OVF_COUNT_EN
- Defined:
  - Adds output ovf_count [7:0].
  - Increments on every rejected write (wr_en & wfull); saturates at 255.
  - Cleared by wr_rst or ovf_clr; if ovf_clr coincides with a rejected write, the count becomes 1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Assert wr_rst 2 cycles with wr_en=1, rptr=0 -> wptr=0x00, wr_mem_en=0, wr_ack=0, overflow=0, wlevel=0, wfull=0 throughout.
2. rptr=0, 90 consecutive writes:
   - waddr steps 0..89.
   - walmost_full rises the cycle wlevel reaches 80.
   - After the 90th write: wptr=0x80, wlevel=90, wfull=1.
   - wr_ack high on 90 consecutive cycles, each one edge after its write.
3. Continue from full, wr_en=1 for 3 cycles -> wr_mem_en=0, wptr stays 0x80, wr_ack=0, overflow=1 from next edge; with OVF_COUNT_EN, ovf_count=3.
4. Wrap-distinct level: drive wptr to 0x85 via writes, set rptr=0x50 -> wlevel=15, wfull=0, walmost_full=0.
5. overflow=1, then same cycle ovf_clr=1 and wr_en=1 with wfull=1 -> overflow stays 1. Next cycle ovf_clr=1, wr_en=0 -> overflow=0.
6. Mid-burst reset after 10 writes (wptr=0x0A) with wr_en held high -> next edge wptr=0, wr_ack=0. Writes resume on the first edge after wr_rst deasserts.
